// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped, read-only instruction cache that answers the fetch stage's PC
// reads. Hits are returned combinationally in the same cycle (zero latency).
// On a miss the fetch stage is stalled through o_p_waitrequest while one whole
// line is fetched from backing memory with a single pipelined read burst.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   p_addr            fetch PC, byte address (bits [1:0] ignored)
//   p_read            fetch read request
//   p_readdata        instruction word at p_addr (valid when waitrequest low)
//   o_p_waitrequest   high = p_readdata not valid, fetch must hold
//   flush             one-cycle pulse, invalidates every line
//   m_address         line-aligned burst start address
//   m_read            burst read request
//   m_waitrequest     memory not accepting the request this cycle
//   m_readdata        returned burst word
//   m_readdatavalid   m_readdata carries a burst beat this cycle
//
// Handshakes
//   Fetch side: a read completes in the cycle where p_read=1 and
//   o_p_waitrequest=0; p_readdata is valid only in that cycle.
//   Memory side: the request is transferred on the first clock edge where
//   m_read=1 and m_waitrequest=0; m_read and m_address are held stable until
//   then. Beats arrive in order, one per cycle with m_readdatavalid=1, and are
//   only consumed while the FSM is in FILL.
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p_addr,
  input  logic        p_read,
  output logic [31:0] p_readdata,
  output logic        o_p_waitrequest,
  input  logic        flush,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  // FSM state register; kept as a named enum so checkers can bind to it.
  state_t state, state_d;

  // Address split of the current fetch PC.
  logic [OFF_W-1:0] cur_off;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;

  assign cur_off = p_addr[OFF_W+1:2];
  assign cur_idx = p_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign cur_tag = p_addr[31:IDX_W+OFF_W+2];

  // Byte-lane bits of the PC carry no information for word fetches.
  logic unused_addr_bits;
  assign unused_addr_bits = ^p_addr[1:0];

  // Storage. Only the valid bits are reset; data and tags are don't-care
  // until their line is marked valid.
  logic [31:0]      data_arr [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [LINES-1:0] valid, valid_d;

  // Miss bookkeeping.
  logic [IDX_W-1:0] miss_idx, miss_idx_d;
  logic [TAG_W-1:0] miss_tag, miss_tag_d;
  logic [OFF_W-1:0] beat, beat_d;
  logic             flush_pending, flush_pending_d;
  logic             m_read_d;
  logic [31:0]      m_address_d;
  logic             data_we;
  logic             tag_we;

  logic hit;
  assign hit = valid[cur_idx] && (tag_arr[cur_idx] == cur_tag);

  // Fetch-side outputs. Both are forced low while reset is asserted so the
  // fetch stage never sees a stall or stale data during reset.
  assign p_readdata      = rst ? data_arr[{cur_idx, cur_off}] : 32'h0;
  assign o_p_waitrequest = rst && p_read && ((state != IDLE) || !hit);

  // ---------------------------------------------------------------------------
  // Next-state / next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state;
    valid_d         = valid;
    miss_idx_d      = miss_idx;
    miss_tag_d      = miss_tag;
    beat_d          = beat;
    flush_pending_d = flush_pending;
    m_read_d        = m_read;
    m_address_d     = m_address;
    data_we         = 1'b0;
    tag_we          = 1'b0;

    case (state)
      IDLE: begin
        // Flush takes effect at this edge; the hit test above already used
        // the pre-flush valid bits, so a same-cycle read is served normally.
        if (flush) begin
          valid_d = '0;
        end
        if (p_read && !hit) begin
          miss_idx_d  = cur_idx;
          miss_tag_d  = cur_tag;
          m_address_d = {p_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
          m_read_d    = 1'b1;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (flush) begin
          flush_pending_d = 1'b1;
        end
        if (!m_waitrequest) begin
          m_read_d = 1'b0;
          beat_d   = '0;
          state_d  = FILL;
        end
      end

      FILL: begin
        if (flush) begin
          flush_pending_d = 1'b1;
        end
        if (m_readdatavalid) begin
          data_we = 1'b1;
          beat_d  = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            tag_we          = 1'b1;
            state_d         = IDLE;
            flush_pending_d = 1'b0;
            // A flush seen at any point during the miss (including this
            // final cycle) wins over installing the freshly filled line.
            if (flush_pending || flush) begin
              valid_d = '0;
            end else begin
              valid_d[miss_idx] = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers (asynchronous active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      valid         <= '0;
      miss_idx      <= '0;
      miss_tag      <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
      m_read        <= 1'b0;
      m_address     <= 32'h0;
    end else begin
      state         <= state_d;
      valid         <= valid_d;
      miss_idx      <= miss_idx_d;
      miss_tag      <= miss_tag_d;
      beat          <= beat_d;
      flush_pending <= flush_pending_d;
      m_read        <= m_read_d;
      m_address     <= m_address_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data and tag arrays (no reset, plain write ports)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_arr[{miss_idx, beat}] <= m_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_arr[miss_idx] <= miss_tag;
    end
  end

endmodule
